// File: rtl/pmux_pkg.sv
// pmux_pkg: shared helpers for the pipelined mux tree.
package pmux_pkg;

    // Number of 4:1 levels needed to cover w select bits.
    function automatic int clog4(input int w);
        return (w + 1) / 2;
    endfunction

    function automatic bit pmux_legal(input int sel_w, input int levels);
        return sel_w >= 1 && levels == clog4(sel_w);
    endfunction

endpackage

// File: rtl/mux4_node.sv
// mux4_node: combinational 4:1 word mux, one node of the tree.
module mux4_node
    import pmux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [4*DATA_W-1:0] in_data,
    input  logic [1:0]          in_sel,
    output logic [DATA_W-1:0]   out_data
);

    assign out_data = in_data[in_sel*DATA_W +: DATA_W];

endmodule

// File: rtl/pipelined_mux_tree.sv
// pipelined_mux_tree: N:1 word mux built from 4:1 nodes, registered after every level,
// with a valid/ready handshake that stalls the whole pipe.
module pipelined_mux_tree
    import pmux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [(2**SEL_W)*DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]             in_sel,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [SEL_W-1:0]             out_sel,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int N      = 2**SEL_W;
    localparam int LEVELS = clog4(SEL_W);
    localparam int NP     = 4**LEVELS;

    // Word offset of level k inside the flat stage-data register.
    function automatic int word_off(input int k);
        int s = 0;
        for (int i = 0; i < k; i++) s += NP >> (2*i + 2);
        return s;
    endfunction

    localparam int TOTW = word_off(LEVELS);

    logic [TOTW*DATA_W-1:0] r_data;
    logic [TOTW*DATA_W-1:0] w_nxt;
    logic [LEVELS-1:0]      r_valid;
    logic [LEVELS-1:0]      w_vnxt;
    logic [SEL_W-1:0]       r_sel  [LEVELS];
    logic [SEL_W-1:0]       w_snxt [LEVELS];
    logic [NP*DATA_W-1:0]   w_pad;
    logic                   w_stall;

    if (!pmux_legal(SEL_W, LEVELS) || DATA_W < 1) begin : g_bad
        $error("pipelined_mux_tree: illegal SEL_W/DATA_W");
    end

    // Odd SEL_W: zero words pad the tree to a power of 4; the 0 upper sel bit never reaches them.
    if (NP == N) begin : g_nopad
        assign w_pad = in_data;
    end else begin : g_pad
        assign w_pad = {{((NP - N)*DATA_W){1'b0}}, in_data};
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int WK  = NP >> (2*k + 2);
        localparam int OFF = word_off(k);
        logic [4*WK*DATA_W-1:0] w_lin;
        logic [1:0]             w_pair;
        if (k == 0) begin : g_first
            assign w_lin     = w_pad;
            assign w_vnxt[0] = in_valid;
            assign w_snxt[0] = in_sel;
        end else begin : g_next
            assign w_lin     = r_data[word_off(k-1)*DATA_W +: 4*WK*DATA_W];
            assign w_vnxt[k] = r_valid[k-1];
            assign w_snxt[k] = r_sel[k-1];
        end
        if (2*k + 1 < SEL_W) begin : g_pair2
            assign w_pair = w_snxt[k][2*k+1:2*k];
        end else begin : g_pair1
            assign w_pair = {1'b0, w_snxt[k][2*k]};
        end
        for (genvar j = 0; j < WK; j++) begin : g_node
            mux4_node #(.DATA_W(DATA_W)) u_node (
                .in_data  (w_lin[j*4*DATA_W +: 4*DATA_W]),
                .in_sel   (w_pair),
                .out_data (w_nxt[(OFF + j)*DATA_W +: DATA_W])
            );
        end
    end

    assign out_valid = r_valid[LEVELS-1];
    assign out_data  = r_data[TOTW*DATA_W-1 -: DATA_W];
    assign out_sel   = r_sel[LEVELS-1];
    assign w_stall   = out_valid & ~out_ready;
    assign in_ready  = ~w_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= '0;
            r_sel   <= '{default: '0};
        end else if (!w_stall) begin
            r_data  <= w_nxt;
            r_valid <= w_vnxt;
            r_sel   <= w_snxt;
        end
    end

endmodule

// File: tb/tb_pipelined_mux_tree.sv
// tb_pipelined_mux_tree: directed and random checks of the pipelined mux tree against a delay-line model.
module tb_pipelined_mux_tree;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [127:0] in_data;
    logic [3:0]   in_sel;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [7:0]   out_data;
    logic [3:0]   out_sel;

    logic [31:0]  t_in_data;
    logic [2:0]   t_in_sel, t_out_sel;
    logic         t_in_valid, t_in_ready, t_out_valid, t_out_ready;
    logic [3:0]   t_out_data;

    logic [15:0]  o_in_data;
    logic         o_in_sel, o_out_sel;
    logic         o_in_valid, o_in_ready, o_out_valid, o_out_ready;
    logic [7:0]   o_out_data;

    int total = 0;
    int bad   = 0;

    pipelined_mux_tree #(.DATA_W(8), .SEL_W(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    pipelined_mux_tree #(.DATA_W(4), .SEL_W(3)) dut3 (
        .clk(clk), .rst(rst), .in_data(t_in_data), .in_sel(t_in_sel), .in_valid(t_in_valid),
        .in_ready(t_in_ready), .out_data(t_out_data), .out_sel(t_out_sel), .out_valid(t_out_valid),
        .out_ready(t_out_ready)
    );

    pipelined_mux_tree #(.DATA_W(8), .SEL_W(1)) dut1 (
        .clk(clk), .rst(rst), .in_data(o_in_data), .in_sel(o_in_sel), .in_valid(o_in_valid),
        .in_ready(o_in_ready), .out_data(o_out_data), .out_sel(o_out_sel), .out_valid(o_out_valid),
        .out_ready(o_out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: every non-stalled edge pushes the offered slot (bubble or item) into a
    // 2-deep delay line; the oldest slot of a full line is what the output must show.
    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [3:0] s;
    } item_t;

    item_t q[$];
    item_t ce;

    function automatic item_t head();
        item_t e;
        e = '{v: 1'b0, d: 8'h0, s: 4'h0};
        if (q.size() == 2) e = q[0];
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else if (!(head().v && !out_ready)) begin
            q.push_back('{v: in_valid, d: in_data[int'(in_sel)*8 +: 8], s: in_sel});
            if (q.size() > 2) void'(q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            ce = head();
            chk("model out_valid", out_valid, ce.v);
            if (ce.v) begin
                chk("model out_data", out_data, ce.d);
                chk("model out_sel", out_sel, ce.s);
            end
            chk("model in_ready", in_ready, !(ce.v && !out_ready));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_a0();
        for (int i = 0; i < 16; i++) in_data[i*8 +: 8] = 8'(8'hA0 + i);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        in_data = '0; in_sel = '0; in_valid = 1'b0; out_ready = 1'b1;
        t_in_data = '0; t_in_sel = '0; t_in_valid = 1'b0; t_out_ready = 1'b1;
        o_in_data = '0; o_in_sel = 1'b0; o_in_valid = 1'b0; o_out_ready = 1'b1;
        // reset held with random traffic
        repeat (3) begin
            tick();
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            in_sel   = 4'($urandom);
            in_valid = 1'($urandom);
            #1;
            chk("rst out_valid", out_valid, 0);
            chk("rst out_data", out_data, 0);
            chk("rst out_sel", out_sel, 0);
            chk("rst in_ready", in_ready, 1);
        end
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        set_a0();
        // asynchronous reset in the middle of a stream
        repeat (4) begin
            tick();
            in_valid = 1'b1;
            in_sel   = 4'($urandom);
        end
        tick();
        chk("pre-rst out_valid", out_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("async rst out_valid", out_valid, 0);
        chk("async rst out_data", out_data, 0);
        tick();
        tick();
        rst = 1'b0;
        #1 chk("release c0 out_valid", out_valid, 0);
        tick();
        in_valid = 1'b0;
        #1 chk("release c1 out_valid", out_valid, 0);
        drain();
        // back-to-back sweep
        in_sel   = 4'd0;
        in_valid = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            chk("sweep out_valid", out_valid, (c >= 2 && c <= 17));
            if (c >= 2 && c <= 17) begin
                chk("sweep out_data", out_data, 8'hA0 + c - 2);
                chk("sweep out_sel", out_sel, c - 2);
            end
            if (c < 16) in_sel = 4'(c);
            else in_valid = 1'b0;
        end
        drain();
        // stall
        in_sel = 4'd3; in_valid = 1'b1;
        tick();
        in_sel = 4'd7;
        #1 chk("stall c1 out_valid", out_valid, 0);
        tick();
        in_sel = 4'd11; out_ready = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            #1;
            chk("stall in_ready", in_ready, 0);
            chk("stall out_valid", out_valid, 1);
            chk("stall out_data", out_data, 8'hA3);
            if (c < 5) tick();
        end
        tick();
        out_ready = 1'b1;
        #1;
        chk("unstall out_data", out_data, 8'hA3);
        chk("unstall in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("stall next A7", out_data, 8'hA7);
        chk("stall next valid", out_valid, 1);
        tick();
        chk("stall next AB", out_data, 8'hAB);
        chk("stall next sel", out_sel, 11);
        tick();
        chk("stall end valid", out_valid, 0);
        drain();
        // bubbles
        in_sel = 4'd5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_sel = 4'($urandom);
        tick();
        in_valid = 1'b1; in_sel = 4'd9;
        chk("bubble A5 valid", out_valid, 1);
        chk("bubble A5 data", out_data, 8'hA5);
        tick();
        in_valid = 1'b0;
        chk("bubble gap valid", out_valid, 0);
        tick();
        chk("bubble A9 valid", out_valid, 1);
        chk("bubble A9 data", out_data, 8'hA9);
        drain();
        // input change after accept
        in_sel = 4'd2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        tick();
        chk("captured A2", out_data, 8'hA2);
        set_a0();
        drain();
        // odd widths
        for (int i = 0; i < 8; i++) t_in_data[i*4 +: 4] = 4'(i);
        t_in_sel = 3'd7; t_in_valid = 1'b1;
        o_in_data = {8'h5B, 8'h3C}; o_in_sel = 1'b1; o_in_valid = 1'b1;
        tick();
        t_in_valid = 1'b0; o_in_valid = 1'b0;
        chk("sel3 c1 valid", t_out_valid, 0);
        chk("sel3 in_ready", t_in_ready, 1);
        chk("sel1 c1 valid", o_out_valid, 1);
        chk("sel1 data", o_out_data, 8'h5B);
        chk("sel1 sel", o_out_sel, 1);
        chk("sel1 in_ready", o_in_ready, 1);
        tick();
        t_in_sel = 3'd2; t_in_valid = 1'b1;
        o_in_sel = 1'b0; o_in_valid = 1'b1;
        chk("sel3 c2 valid", t_out_valid, 1);
        chk("sel3 data", t_out_data, 4'h7);
        chk("sel3 sel", t_out_sel, 7);
        chk("sel1 c2 valid", o_out_valid, 0);
        tick();
        t_in_valid = 1'b0; o_in_valid = 1'b0;
        chk("sel1 word0", o_out_data, 8'h3C);
        tick();
        chk("sel3 word2", t_out_data, 4'h2);
        // random traffic
        for (int c = 0; c < 3000; c++) begin
            tick();
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) in_data = {$urandom, $urandom, $urandom, $urandom};
        end
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
